// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: 2x-scaled VGA scanout prefetch FIFO plus writer port.
// Define VGA_ARB_STATS_EN to add underrun_cnt / wr_stall_cnt counters.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int H_PIX      = 320,
  parameter int V_PIX      = 240,
  parameter int VACTIVE    = 480,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 4
) (
  input  logic              vgaclk,
  input  logic              rst_n,
  input  logic [9:0]        counter_H,
  input  logic [9:0]        counter_V,
  input  logic              vga_blank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              underrun
`ifdef VGA_ARB_STATS_EN
  ,
  output logic [15:0]       underrun_cnt,
  output logic [15:0]       wr_stall_cnt
`endif
);

  localparam int FX_W  = $clog2(H_PIX);
  localparam int FY_W  = $clog2(V_PIX);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_DONE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;

  localparam logic [FX_W-1:0]   L_FX_LAST = FX_W'(H_PIX - 1);
  localparam logic [FY_W-1:0]   L_FY_LAST = FY_W'(V_PIX - 1);
  localparam logic [ADDR_W-1:0] L_LINE    = ADDR_W'(H_PIX);
  localparam logic [CNT_W:0]    L_DEPTH   = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0]    L_LOW     = (CNT_W+1)'(LOW_WATER);
  localparam logic [9:0]        L_VRST    = 10'(VACTIVE);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nx;
  logic [FX_W-1:0]   r_fx;
  logic [FY_W-1:0]   r_fy;
  logic              r_rep;
  logic [ADDR_W-1:0] r_line_base;
  logic              r_inflight;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [CNT_W-1:0]  r_count;
  logic              r_underrun;

  logic              w_restart;
  logic              w_flush;
  logic              w_fetch;
  logic [CNT_W:0]    w_occ;
  logic              w_need;
  logic              w_urgent;
  logic              w_wr_go;
  logic              w_rd_go;
  logic              w_last_fx;
  logic              w_final;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_pop_ok;
  logic              w_pop_empty;

  assign w_restart = (counter_V == L_VRST) && (counter_H == 10'd0);
  assign w_flush   = (r_state == S_FLUSH);
  assign w_fetch   = (r_state == S_FETCH);

  // In-flight read counts as occupied so a push never meets a full FIFO
  assign w_occ    = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_need   = w_fetch && (w_occ < L_DEPTH);
  assign w_urgent = w_need && (w_occ < L_LOW);

  assign w_wr_go = wr_valid && !w_urgent && !w_flush;
  assign w_rd_go = w_urgent || (w_need && !w_wr_go);

  assign w_last_fx    = (r_fx == L_FX_LAST);
  assign w_final      = w_last_fx && r_rep && (r_fy == L_FY_LAST);
  assign w_fetch_addr = r_line_base + ADDR_W'(r_fx);

  assign wr_ready  = w_wr_go;
  assign mem_we    = w_wr_go;
  assign mem_wdata = w_wr_go ? wr_data : '0;
  assign mem_addr  = w_wr_go ? wr_addr
                   : (w_rd_go ? w_fetch_addr : '0);

  assign w_push      = r_inflight && !w_flush;
  assign w_pop       = vga_blank && counter_H[0];
  assign w_empty     = (r_count == '0);
  assign w_pop_ok    = w_pop && !w_empty;
  assign w_pop_empty = w_pop && w_empty;

  assign pix_data = (vga_blank && !w_empty) ? r_mem[r_rp] : '0;
  assign underrun = r_underrun;

  always_comb begin
    w_state_nx = r_state;
    if (w_restart)
      w_state_nx = S_FLUSH;
    else if (w_flush)
      w_state_nx = S_FETCH;
    else if (w_fetch && w_rd_go && w_final)
      w_state_nx = S_DONE;
  end

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_DONE;
      r_inflight <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_inflight <= w_rd_go;
      if (w_pop_empty)
        r_underrun <= 1'b1;
    end
  end

  // Each source line is fetched twice (rep) before advancing
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      r_fx        <= '0;
      r_fy        <= '0;
      r_rep       <= 1'b0;
      r_line_base <= '0;
    end else if (w_flush) begin
      r_fx        <= '0;
      r_fy        <= '0;
      r_rep       <= 1'b0;
      r_line_base <= '0;
    end else if (w_rd_go) begin
      if (w_last_fx) begin
        r_fx <= '0;
        if (!r_rep) begin
          r_rep <= 1'b1;
        end else begin
          r_rep       <= 1'b0;
          r_fy        <= r_fy + 1'b1;
          r_line_base <= r_line_base + L_LINE;
        end
      end else begin
        r_fx <= r_fx + 1'b1;
      end
    end
  end

  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop_ok)
        r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop_ok)
        r_count <= r_count + 1'b1;
      else if (!w_push && w_pop_ok)
        r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge vgaclk) begin
    if (w_push)
      r_mem[r_wp] <= mem_rdata;
  end

`ifdef VGA_ARB_STATS_EN
  always_ff @(posedge vgaclk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
      wr_stall_cnt <= '0;
    end else begin
      if (w_pop_empty && (underrun_cnt != 16'hFFFF))
        underrun_cnt <= underrun_cnt + 16'd1;
      if (wr_valid && !w_wr_go && (wr_stall_cnt != 16'hFFFF))
        wr_stall_cnt <= wr_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: directed table, scanout sequences, random model.
// Build with VGA_ARB_STATS_EN to also check the statistics counters.
module tb_vga_fb_arbiter;

  logic        vgaclk = 1'b0;
  logic        rst_n;
  logic [9:0]  counter_H;
  logic [9:0]  counter_V;
  logic        vga_blank;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  pix_data;
  logic        underrun;
`ifdef VGA_ARB_STATS_EN
  logic [15:0] underrun_cnt;
  logic [15:0] wr_stall_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  vga_fb_arbiter dut (
    .vgaclk    (vgaclk),
    .rst_n     (rst_n),
    .counter_H (counter_H),
    .counter_V (counter_V),
    .vga_blank (vga_blank),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pix_data  (pix_data),
    .underrun  (underrun)
`ifdef VGA_ARB_STATS_EN
    ,
    .underrun_cnt (underrun_cnt),
    .wr_stall_cnt (wr_stall_cnt)
`endif
  );

  always #5 vgaclk = ~vgaclk;

  // RAM model: unwritten words hold a fixed address pattern
  logic [7:0] ram   [131072];
  bit         wrote [131072];

  function automatic logic [7:0] ram_rd(logic [16:0] a);
    if (wrote[a])
      return ram[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge vgaclk) begin
    if (mem_we) begin
      ram[mem_addr]   <= mem_wdata;
      wrote[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_rd(mem_addr);
  end

  // k-th scanout fetch: each 320-word source line read twice
  function automatic logic [16:0] fa(int k);
    return 17'((k / 640) * 320 + (k % 320));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [9:0] h, logic [9:0] v, logic b,
                       logic wv, logic [16:0] wa, logic [7:0] wd);
    counter_H = h;
    counter_V = v;
    vga_blank = b;
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
  endtask

  task automatic tick;
    @(posedge vgaclk);
    #1;
  endtask

  // Holds reset a cycle with a pending pop and writer, checking reset outputs
  task automatic reset_chk;
    rst_n = 1'b0;
    drive(10'd1, 10'd200, 1'b1, 1'b0, 17'h0, 8'h0);
    #3;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_pix", 32'(pix_data), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_rdy_idle", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1;
    wr_addr  = 17'h1F00;
    #1;
    chk("rst_rdy_req", 32'(wr_ready), 32'd1);
    drive(10'd0, 10'd200, 1'b0, 1'b0, 17'h0, 8'h0);
    tick;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        wv;
    logic [16:0] wa;
    logic [7:0]  wd;
    logic        e_we;
    logic        e_rdy;
    logic [16:0] e_addr;
  } vec_t;

  function automatic vec_t mk(int h, int v, bit wv, int wa, int wd,
                              bit we, bit rdy, int addr);
    vec_t r;
    r.h = 10'(h); r.v = 10'(v); r.wv = wv;
    r.wa = 17'(wa); r.wd = 8'(wd);
    r.e_we = we; r.e_rdy = rdy; r.e_addr = 17'(addr);
    return r;
  endfunction

  vec_t tbl[15];

  // Random-phase reference state
  bit         m_fl, m_fe, m_infl, m_und;
  int         m_k;
  logic [7:0] m_infl_d;
  logic [7:0] q[$];

  initial begin
    drive(10'd0, 10'd0, 1'b0, 1'b0, 17'h0, 8'h0);
    rst_n = 1'b0;
    tick;
    reset_chk;

    tbl[0]  = mk(0,  100, 1, 'h100, 'hA5, 1, 1, 'h100);
    tbl[1]  = mk(0,  480, 0, 0,     0,    0, 0, 0);
    tbl[2]  = mk(1,  480, 1, 'h5,   'h11, 0, 0, 0);
    tbl[3]  = mk(2,  480, 0, 0,     0,    0, 0, 0);
    tbl[4]  = mk(3,  480, 1, 'h200, 'h01, 0, 0, 1);
    tbl[5]  = mk(4,  480, 0, 0,     0,    0, 0, 2);
    tbl[6]  = mk(5,  480, 1, 'h201, 'h02, 0, 0, 3);
    tbl[7]  = mk(6,  480, 1, 'h300, 'h3C, 1, 1, 'h300);
    tbl[8]  = mk(7,  480, 0, 0,     0,    0, 0, 4);
    tbl[9]  = mk(8,  480, 0, 0,     0,    0, 0, 5);
    tbl[10] = mk(9,  480, 0, 0,     0,    0, 0, 6);
    tbl[11] = mk(10, 480, 0, 0,     0,    0, 0, 7);
    tbl[12] = mk(11, 480, 1, 'h10,  'h77, 1, 1, 'h10);
    tbl[13] = mk(12, 480, 0, 0,     0,    0, 0, 0);
    tbl[14] = mk(13, 480, 0, 0,     0,    0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].h, tbl[i].v, 1'b0, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      #3;
      chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_rdy", i), 32'(wr_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      if (tbl[i].e_we)
        chk($sformatf("tbl%0d_wd", i), 32'(mem_wdata), 32'(tbl[i].wd));
      chk($sformatf("tbl%0d_pix", i), 32'(pix_data), 32'd0);
      tick;
    end

    // Line pair scanout: pixel j shown on clocks 2j and 2j+1
    for (int c = 0; c < 1282; c++) begin
      drive(10'(c % 640), 10'd10, 1'b1, 1'b0, 17'h0, 8'h0);
      #3;
      chk($sformatf("scan_pix%0d", c), 32'(pix_data),
          32'(ram_rd(fa(c / 2))));
      tick;
    end
    chk("scan_underrun", 32'(underrun), 32'd0);

    // Visible area after reset, before any frame restart
    reset_chk;
    for (int c = 0; c < 640; c++) begin
      drive(10'(c), 10'd20, 1'b1, 1'b0, 17'h0, 8'h0);
      #3;
      chk($sformatf("idle_pix%0d", c), 32'(pix_data), 32'd0);
      chk($sformatf("idle_und%0d", c), 32'(underrun), 32'(c >= 2));
      tick;
    end
    drive(10'd640, 10'd20, 1'b0, 1'b0, 17'h0, 8'h0);
    #3;
`ifdef VGA_ARB_STATS_EN
    chk("underrun_cnt", 32'(underrun_cnt), 32'd320);
    chk("wr_stall_cnt", 32'(wr_stall_cnt), 32'd0);
`endif
    tick;

    // Randomized traffic against the reference model
    reset_chk;
    m_fl = 0; m_fe = 0; m_infl = 0; m_und = 0; m_k = 0;
    m_infl_d = '0;
    q.delete();
    for (int c = 0; c < 5000; c++) begin
      int         occ;
      bit         need, urg, rdy, rd, pop, rst;
      logic [16:0] ea;
      logic [7:0]  ep;
      logic [9:0]  h, v;
      if ($urandom_range(0, 99) < 3) begin
        v = 10'd480;
        h = 10'd0;
      end else begin
        v = 10'($urandom_range(0, 524));
        h = 10'($urandom_range(0, 799));
      end
      drive(h, v, 1'($urandom_range(0, 9) < 6), 1'($urandom),
            17'($urandom), 8'($urandom));
      #3;
      occ  = q.size() + int'(m_infl);
      need = m_fe && (occ < 8);
      urg  = need && (occ < 4);
      rdy  = wr_valid && !urg && !m_fl;
      rd   = urg || (need && !rdy);
      ea   = rdy ? wr_addr : (rd ? fa(m_k) : 17'h0);
      ep   = (vga_blank && q.size() > 0) ? q[0] : 8'h0;
      chk($sformatf("rnd%0d_rdy", c), 32'(wr_ready), 32'(rdy));
      chk($sformatf("rnd%0d_we", c), 32'(mem_we), 32'(rdy));
      chk($sformatf("rnd%0d_addr", c), 32'(mem_addr), 32'(ea));
      chk($sformatf("rnd%0d_wd", c), 32'(mem_wdata),
          32'(rdy ? wr_data : 8'h0));
      chk($sformatf("rnd%0d_pix", c), 32'(pix_data), 32'(ep));
      chk($sformatf("rnd%0d_und", c), 32'(underrun), 32'(m_und));
      pop = vga_blank && h[0];
      rst = (v == 10'd480) && (h == 10'd0);
      if (pop && q.size() == 0)
        m_und = 1;
      else if (pop)
        void'(q.pop_front());
      if (m_fl) begin
        q.delete();
        m_infl = 0;
        m_k    = 0;
      end else begin
        if (m_infl)
          q.push_back(m_infl_d);
        m_infl = rd;
        if (rd) begin
          m_infl_d = ram_rd(fa(m_k));
          m_k++;
        end
      end
      if (rst) begin
        m_fl = 1;
        m_fe = 0;
      end else if (m_fl) begin
        m_fl = 0;
        m_fe = 1;
      end else if (m_fe && rd && m_k == 153600) begin
        m_fe = 0;
      end
      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
